// File: rtl/ssp_serial_receiver.sv
// ---------------------------------------------------------------------------
// ssp_serial_receiver
//
// Receive half of the SSP block, TI-style synchronous serial framing.
// A one-cycle frame-sync pulse precedes each word. The word then arrives MSB
// first, one bit per sspclkin edge. Each completed word is parallelised into
// a holding register and flagged with valid_data until the consumer pulses
// rd_ack.
//
// The receiver never stalls. A word that completes while the holding register
// is still unread and not being acknowledged is dropped (overrun). A word that
// completes on the same edge as an acknowledge replaces the acknowledged word.
// ---------------------------------------------------------------------------
module ssp_serial_receiver #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sspclkin,
    input  logic                  rst_i,
    input  logic                  sspfssin,
    input  logic                  ssprxd,
    input  logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] ssprxout,
    output logic                  valid_data
);

    // Bit counter only has to index bits 0..DATA_WIDTH-1 within a frame.
    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECEIVE = 1'b1
    } state_t;

    // Framing state
    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [CNT_W-1:0]      w_bit_cnt_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;

    // Word assembled from the shift register plus the bit on the wire now.
    // On the LSB edge this is the completed word.
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_word_done;

    // Holding register and its valid flag
    logic [DATA_WIDTH-1:0] r_rxout;
    logic [DATA_WIDTH-1:0] w_rxout_next;
    logic                  r_valid;
    logic                  w_valid_next;

    assign w_word = {r_shift[DATA_WIDTH-2:0], ssprxd};

    // Framing FSM: next state, bit counter, shifter and word-complete strobe
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_word_done    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Serial data is ignored until a frame sync is seen.
                if (sspfssin) begin
                    w_state_next   = ST_RECEIVE;
                    w_bit_cnt_next = '0;
                end
            end

            ST_RECEIVE: begin
                // Shifting continues regardless of the holding-register state.
                w_shift_next = w_word;
                if (r_bit_cnt == LAST_BIT) begin
                    w_word_done    = 1'b1;
                    w_bit_cnt_next = '0;
                    // A sync on the LSB cycle starts the next frame with no gap;
                    // sync during earlier bits is deliberately ignored.
                    w_state_next   = sspfssin ? ST_RECEIVE : ST_IDLE;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_next   = ST_IDLE;
                w_bit_cnt_next = '0;
            end
        endcase
    end

    // Holding register: load on a completed word unless it would overwrite an
    // unread, unacknowledged word; an acknowledge alone clears valid.
    always_comb begin
        w_rxout_next = r_rxout;
        w_valid_next = r_valid;

        if (w_word_done) begin
            if (!r_valid || rd_ack) begin
                w_rxout_next = w_word;
                w_valid_next = 1'b1;
            end
        end else if (rd_ack) begin
            w_valid_next = 1'b0;
        end
    end

    // State registers; reset aborts any frame in progress
    always_ff @(posedge sspclkin) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rxout   <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_rxout   <= w_rxout_next;
            r_valid   <= w_valid_next;
        end
    end

    assign ssprxout   = r_rxout;
    assign valid_data = r_valid;

endmodule

// File: tb/tb_ssp_serial_receiver.sv
// ---------------------------------------------------------------------------
// tb_ssp_serial_receiver
//
// Directed scenarios followed by randomized traffic. A frame-level model
// (busy flag, bit count, integer accumulator) predicts ssprxout/valid_data;
// a compare process checks the DUT against it every cycle, and literal
// checks pin the model in the directed scenarios.
// ---------------------------------------------------------------------------
module tb_ssp_serial_receiver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         sspfssin = 1'b0;
    logic         ssprxd = 1'b0;
    logic         rd_ack = 1'b0;
    logic [W-1:0] ssprxout;
    logic         valid_data;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // Model state
    bit           m_busy = 1'b0;
    int           m_nbits = 0;
    int           m_acc = 0;
    logic [W-1:0] m_out = '0;
    logic         m_valid = 1'b0;

    ssp_serial_receiver #(.DATA_WIDTH(W)) dut (
        .sspclkin   (clk),
        .rst_i      (rst_i),
        .sspfssin   (sspfssin),
        .ssprxd     (ssprxd),
        .rd_ack     (rd_ack),
        .ssprxout   (ssprxout),
        .valid_data (valid_data)
    );

    always #5 clk = ~clk;

    // Apply one edge worth of inputs to the frame-level model.
    task automatic model_edge(input logic rst, input logic fs, input logic rxd, input logic ack);
        bit done;
        int word;
        done = 1'b0;
        word = 0;
        if (rst) begin
            m_busy = 1'b0; m_nbits = 0; m_acc = 0;
            m_out = '0; m_valid = 1'b0;
        end else begin
            if (m_busy) begin
                m_acc = m_acc * 2 + int'(rxd);
                m_nbits++;
                if (m_nbits == W) begin
                    done = 1'b1;
                    word = m_acc;
                    m_busy = fs;
                    m_nbits = 0;
                    m_acc = 0;
                end
            end else if (fs) begin
                m_busy = 1'b1; m_nbits = 0; m_acc = 0;
            end
            if (done) begin
                if (!m_valid || ack) begin
                    m_out = W'(word);
                    m_valid = 1'b1;
                end
            end else if (ack) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Drive inputs, let one rising edge pass, update model, return at the falling edge.
    task automatic step(input logic rst, input logic fs, input logic rxd, input logic ack);
        rst_i = rst; sspfssin = fs; ssprxd = rxd; rd_ack = ack;
        @(posedge clk);
        model_edge(rst, fs, rxd, ack);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [W-1:0] act_out, input logic act_v,
                         input logic [W-1:0] exp_out, input logic exp_v);
        n_cmp++;
        if (act_out !== exp_out || act_v !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got ssprxout=%02h valid=%b, want ssprxout=%02h valid=%b",
                     name, act_out, act_v, exp_out, exp_v);
        end else begin
            $display("ok   %s: ssprxout=%02h valid=%b", name, act_out, act_v);
        end
    endtask

    // Pin both the DUT and the model to a hand-computed value.
    task automatic check_lit(input string name, input logic [W-1:0] exp_out, input logic exp_v);
        check({name, "/dut"}, ssprxout, valid_data, exp_out, exp_v);
        check({name, "/model"}, m_out, m_valid, exp_out, exp_v);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rbit(), 1'b0);
    endtask

    task automatic sync();
        step(1'b0, 1'b1, rbit(), 1'b0);
    endtask

    // Data bits of one frame, MSB first, with optional sync/ack on chosen bits.
    task automatic bits(input logic [W-1:0] word, input bit sync_lsb, input bit ack_first, input bit ack_lsb);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b0, (i == 0) && sync_lsb, word[i],
                 ((i == W - 1) && ack_first) || ((i == 0) && ack_lsb));
        end
    endtask

    // Per-cycle compare of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (ssprxout !== m_out || valid_data !== m_valid) begin
                n_mis++;
                $display("FAIL cycle @%0t: got ssprxout=%02h valid=%b, want ssprxout=%02h valid=%b",
                         $time, ssprxout, valid_data, m_out, m_valid);
            end
        end
    end

    initial begin
        // Reset for 3 edges with random framing inputs
        step(1'b1, rbit(), rbit(), rbit());
        chk_en = 1'b1;
        step(1'b1, rbit(), rbit(), rbit());
        check_lit("reset_mid", 8'h00, 1'b0);
        step(1'b1, rbit(), rbit(), rbit());
        check_lit("reset_end", 8'h00, 1'b0);

        // Single frame 0xCF, hold, then acknowledge
        sync();
        bits(8'hCF, 1'b0, 1'b0, 1'b0);
        check_lit("single_load", 8'hCF, 1'b1);
        idle(5);
        check_lit("single_hold", 8'hCF, 1'b1);
        step(1'b0, 1'b0, rbit(), 1'b1);
        check_lit("single_ack", 8'hCF, 1'b0);

        // Serial data without frame sync must be ignored
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'(i & 1), 1'b0);
        check_lit("no_sync", 8'hCF, 1'b0);

        // Back-to-back: 0xA5 with sync on its LSB, then 0x3C; ack right after first valid
        sync();
        bits(8'hA5, 1'b1, 1'b0, 1'b0);
        check_lit("b2b_first", 8'hA5, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);            // bit 7 of 0x3C, with ack
        check_lit("b2b_acked", 8'hA5, 1'b0);
        for (int i = W - 2; i >= 0; i--) step(1'b0, 1'b0, 1'(8'h3C >> i), 1'b0);
        check_lit("b2b_second", 8'h3C, 1'b1);
        step(1'b0, 1'b0, rbit(), 1'b1);
        check_lit("b2b_clear", 8'h3C, 1'b0);

        // Overrun: 0x55 unread, 0xAA discarded
        sync(); bits(8'h55, 1'b0, 1'b0, 1'b0);
        idle(2);
        sync(); bits(8'hAA, 1'b0, 1'b0, 1'b0);
        check_lit("overrun", 8'h55, 1'b1);
        // Ack on the LSB edge lets the new word in and keeps valid set
        sync(); bits(8'hAA, 1'b0, 1'b0, 1'b1);
        check_lit("ack_on_lsb", 8'hAA, 1'b1);
        step(1'b0, 1'b0, rbit(), 1'b1);
        check_lit("ack_clear", 8'hAA, 1'b0);

        // Reset mid-frame after 4 bits, then a clean 0x81
        sync();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_lit("rst_abort", 8'h00, 1'b0);
        idle(6);
        check_lit("no_partial", 8'h00, 1'b0);
        sync(); bits(8'h81, 1'b0, 1'b0, 1'b0);
        check_lit("after_rst", 8'h81, 1'b1);
        step(1'b0, 1'b0, rbit(), 1'b1);

        // Randomized traffic, checked cycle-by-cycle against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 249) == 0),
                 1'($urandom_range(0, 5) == 0),
                 rbit(),
                 1'($urandom_range(0, 4) == 0));
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
